// File: rtl/generador_pulsos_up_down_pkg.sv
`default_nettype none
// ============================================================================
// Module   : generador_pulsos_up_down_pkg
// Brief    : Shared FSM encodings and 100 MHz board timing defaults.
// Revision : 1.0
// ============================================================================
package generador_pulsos_up_down_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_HOLD   = 2'b01,
      ST_REPEAT = 2'b10
   } estado_t;

   localparam int unsigned C_DEB_CYCLES    = 1000000;   // 10 ms
   localparam int unsigned C_REPEAT_DELAY  = 50000000;  // 0.5 s
   localparam int unsigned C_REPEAT_PERIOD = 10000000;  // 0.1 s
   localparam int unsigned C_CW            = 26;

endpackage
`default_nettype wire

// File: rtl/generador_pulsos_up_down_if.sv
`default_nettype none
// ============================================================================
// Module   : generador_pulsos_up_down_if
// Brief    : Button inputs, counter enable pulses and debounced debug levels.
// Revision : 1.0
// ============================================================================
interface generador_pulsos_up_down_if;

   logic btn_up;
   logic btn_down;
   logic enUP;
   logic enDOWN;
   logic btn_up_db;
   logic btn_down_db;

   modport master (
      output btn_up, btn_down,
      input  enUP, enDOWN, btn_up_db, btn_down_db
   );

   modport slave (
      input  btn_up, btn_down,
      output enUP, enDOWN, btn_up_db, btn_down_db
   );

endinterface
`default_nettype wire

// File: rtl/generador_pulsos_up_down_acondicionador_boton.sv
`default_nettype none
// ============================================================================
// Module   : acondicionador_boton
// Brief    : One button channel: 2-flop sync, debounce, hold-to-repeat FSM.
// Revision : 1.0
// ============================================================================
module acondicionador_boton
   import generador_pulsos_up_down_pkg::*;
#(
   parameter int unsigned DEB_CYCLES    = C_DEB_CYCLES,
   parameter int unsigned REPEAT_DELAY  = C_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD = C_REPEAT_PERIOD,
   parameter int unsigned CW            = C_CW
) (
   input  wire  clk,
   input  wire  reset,
   input  wire  btn_i,
   output logic pulse_o,
   output logic rep_o,
   output logic level_o
);

   localparam logic [CW-1:0] C_DEB_LAST = CW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0] C_DELAY    = CW'(REPEAT_DELAY);
   localparam logic [CW-1:0] C_PERIOD   = CW'(REPEAT_PERIOD);
   localparam logic [CW-1:0] C_ONE      = CW'(1);

   logic          sync1_q, sync2_q;
   logic          stable_q, stable_d;
   logic          level_q;
   logic [CW-1:0] deb_cnt_q, deb_cnt_d;
   logic [CW-1:0] timer_q;
   logic          pulse_q, rep_q;
   estado_t       state_q;

   always_comb begin
      deb_cnt_d = '0;
      stable_d  = stable_q;
      if (sync2_q != stable_q) begin
         if (deb_cnt_q == C_DEB_LAST) begin
            stable_d = sync2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + C_ONE;
         end
      end
   end

   // level_q delays the debounced level so it lines up with the first pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         stable_q  <= 1'b0;
         level_q   <= 1'b0;
         deb_cnt_q <= '0;
      end else begin
         sync1_q   <= btn_i;
         sync2_q   <= sync1_q;
         stable_q  <= stable_d;
         level_q   <= stable_q;
         deb_cnt_q <= deb_cnt_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         pulse_q <= 1'b0;
         rep_q   <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         rep_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (stable_q) begin
                  pulse_q <= 1'b1;
                  timer_q <= C_DELAY;
                  state_q <= ST_HOLD;
               end
            end
            ST_HOLD, ST_REPEAT: begin
               // release wins over a pulse due on the same cycle
               if (!stable_q) begin
                  state_q <= ST_IDLE;
               end else if (timer_q == C_ONE) begin
                  pulse_q <= 1'b1;
                  rep_q   <= 1'b1;
                  timer_q <= C_PERIOD;
                  state_q <= ST_REPEAT;
               end else begin
                  timer_q <= timer_q - C_ONE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign pulse_o = pulse_q;
   assign rep_o   = rep_q;
   assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/generador_pulsos_up_down.sv
`default_nettype none
// ============================================================================
// Module   : generador_pulsos_up_down
// Brief    : Two conditioned button channels with up-priority arbitration.
// Revision : 1.0
// ============================================================================
module generador_pulsos_up_down
   import generador_pulsos_up_down_pkg::*;
#(
   parameter int unsigned DEB_CYCLES    = C_DEB_CYCLES,
   parameter int unsigned REPEAT_DELAY  = C_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD = C_REPEAT_PERIOD,
   parameter int unsigned CW            = C_CW
) (
   input wire clk,
   input wire reset,
   generador_pulsos_up_down_if.slave bus
);

   logic w_up_pulse, w_up_rep, w_up_level;
   logic w_dn_pulse, w_dn_rep, w_dn_level;
   logic w_both, w_up_ok, w_dn_ok;

   acondicionador_boton #(
      .DEB_CYCLES   (DEB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .CW           (CW)
   ) u_up (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (bus.btn_up),
      .pulse_o(w_up_pulse),
      .rep_o  (w_up_rep),
      .level_o(w_up_level)
   );

   acondicionador_boton #(
      .DEB_CYCLES   (DEB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .CW           (CW)
   ) u_down (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (bus.btn_down),
      .pulse_o(w_dn_pulse),
      .rep_o  (w_dn_rep),
      .level_o(w_dn_level)
   );

   // with both buttons held, auto-repeat is muted; up wins any collision
   assign w_both  = w_up_level & w_dn_level;
   assign w_up_ok = w_up_pulse & ~(w_up_rep & w_both);
   assign w_dn_ok = w_dn_pulse & ~(w_dn_rep & w_both);

   assign bus.enUP        = w_up_ok;
   assign bus.enDOWN      = w_dn_ok & ~w_up_ok;
   assign bus.btn_up_db   = w_up_level;
   assign bus.btn_down_db = w_dn_level;

endmodule
`default_nettype wire

// File: tb/tb_generador_pulsos_up_down.sv
`default_nettype none
// ============================================================================
// Module   : tb_generador_pulsos_up_down
// Brief    : Directed bench for the button pulse generator (small timings).
// Revision : 1.0
// ============================================================================
module tb_generador_pulsos_up_down;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   generador_pulsos_up_down_if bus ();

   generador_pulsos_up_down #(
      .DEB_CYCLES   (4),
      .REPEAT_DELAY (20),
      .REPEAT_PERIOD(8),
      .CW           (26)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;
   int overlap  = 0;
   int up_cnt, dn_cnt, db_cnt, db_first, dn_first;
   int up_pos[8];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Edge index i: inputs set before edge i, outputs sampled #1 after edge i.
   task automatic run(input int n, input int up_until, input int dn_until, input bit bounce);
      up_cnt = 0; dn_cnt = 0; db_cnt = 0; db_first = -1; dn_first = -1;
      for (int j = 0; j < 8; j++) up_pos[j] = -1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == 0) reset = 1'b1;
         bus.btn_up   = (i < up_until);
         bus.btn_down = (i < dn_until) && (!bounce || i >= 20 || ((i / 2) % 2 == 0));
         @(posedge clk);
         #1;
         if (bus.enUP && bus.enDOWN) overlap++;
         if (bus.enUP) begin
            if (up_cnt < 8) up_pos[up_cnt] = i;
            up_cnt++;
         end
         if (bus.enDOWN) begin
            if (dn_cnt == 0) dn_first = i;
            dn_cnt++;
         end
         if (bus.btn_up_db) begin
            if (db_cnt == 0) db_first = i;
            db_cnt++;
         end
      end
   endtask

   initial begin
      reset        = 1'b0;
      bus.btn_up   = 1'b1;
      bus.btn_down = 1'b0;

      // 1: reset with button pressed, then release mid-press
      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs", {28'd0, bus.enUP, bus.enDOWN, bus.btn_up_db, bus.btn_down_db}, 32'd0);
      run(20, 20, 0, 1'b0);
      check("rstrel_up_cnt", up_cnt, 1);
      check("rstrel_up_at", up_pos[0], 6);
      run(20, 0, 0, 1'b0);
      check("rstrel_release_no_pulse", up_cnt, 0);

      // 2: clean 10-cycle press
      run(25, 10, 0, 1'b0);
      check("clean_up_cnt", up_cnt, 1);
      check("clean_up_at", up_pos[0], 6);
      check("clean_db_len", db_cnt, 10);
      check("clean_db_first", db_first, 6);
      check("clean_dn_cnt", dn_cnt, 0);
      run(15, 0, 0, 1'b0);

      // 3: bouncing down button, settles high at edge 20
      run(40, 0, 37, 1'b1);
      check("bounce_dn_cnt", dn_cnt, 1);
      check("bounce_dn_at", dn_first, 26);
      check("bounce_up_cnt", up_cnt, 0);
      run(15, 0, 0, 1'b0);
      check("bounce_release_dn_cnt", dn_cnt, 0);

      // 4: hold-to-repeat for 60 cycles
      run(75, 60, 0, 1'b0);
      check("hold_up_cnt", up_cnt, 6);
      check("hold_p0", up_pos[0], 6);
      check("hold_p1", up_pos[1], 26);
      check("hold_p2", up_pos[2], 34);
      check("hold_p5", up_pos[5], 58);
      run(15, 0, 0, 1'b0);

      // 5: simultaneous press, both held
      run(50, 40, 40, 1'b0);
      check("both_up_cnt", up_cnt, 1);
      check("both_up_at", up_pos[0], 6);
      check("both_dn_cnt", dn_cnt, 0);
      run(15, 0, 0, 1'b0);

      // 6: async reset while auto-repeating, button kept held
      run(35, 1000, 0, 1'b0);
      check("rep_up_cnt", up_cnt, 3);
      check("rep_pulse_live", {31'd0, bus.enUP}, 32'd1);
      #1 reset = 1'b0;
      #1;
      check("async_rst_outputs", {28'd0, bus.enUP, bus.enDOWN, bus.btn_up_db, bus.btn_down_db}, 32'd0);
      repeat (3) @(negedge clk);
      check("rst_hold_outputs", {28'd0, bus.enUP, bus.enDOWN, bus.btn_up_db, bus.btn_down_db}, 32'd0);
      run(12, 1000, 0, 1'b0);
      check("rerelease_up_cnt", up_cnt, 1);
      check("rerelease_up_at", up_pos[0], 6);

      check("never_both_pulses", overlap, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
